// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg
// Shared definitions for the Moore FSM sequencer slice.
//   DEF_SW_W / DEF_ST_W : default widths of the core's switch input and state
//   seq_state_t         : controller state encoding
//   clamp_len           : limits a requested run length to the script depth
package moore_seq_pkg;

  localparam int DEF_SW_W = 2;
  localparam int DEF_ST_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    DRIVE,
    STEP,
    CAPT,
    DONE
  } seq_state_t;

  // A run can never be longer than the script, so anything larger is cut
  // down to the depth instead of wrapping the step index.
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/moore_seq_script.sv
// moore_seq_script
// Script store for the sequencer: DEPTH entries of SW_W bits.
//   clk, reset : clock and synchronous active-high reset (clears every entry)
//   wr_en      : write strobe, wr_addr/wr_data land on the next rising edge
//   rd_addr    : read address, rd_data follows it combinationally
module moore_seq_script #(
  parameter int DEPTH = 8,
  parameter int SW_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [SW_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [SW_W-1:0]          rd_data
);

  logic [SW_W-1:0] mem [DEPTH];

  // The storage itself. Reset wipes the whole script so a fresh run after
  // reset drives all-zero symbols unless the host reprograms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads are asynchronous so the controller can present the symbol in the
  // same cycle it enters DRIVE.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/moore_seq_ctrl.sv
// moore_seq_ctrl
// Sequencer that single-steps a 2-state Moore FSM core through a programmed
// run of switch symbols and records the core's response.
//   clk, reset           : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data: script write port, honoured only while idle
//   start, len, clr_fsm  : launch a run of len steps (clamped to DEPTH),
//                          optionally resetting the core first
//   busy, done           : run in progress / one-cycle end-of-run pulse
//   fsm_sw, fsm_ctrl,
//   fsm_reset            : drives to the core (switch, step enable, reset)
//   fsm_state, fsm_out   : observations from the core
//   trace, last_state    : per-step fsm_out capture and final core state
// Build option: define MOORE_SEQ_TRACE_EN to include the CAPT state and the
// trace/last_state capture. Without it a step is DRIVE+STEP only and
// trace/last_state read as zero.
module moore_seq_ctrl
  import moore_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SW_W  = DEF_SW_W,
  parameter int ST_W  = DEF_ST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [SW_W-1:0]          wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     clr_fsm,
  output logic                     busy,
  output logic                     done,
  output logic [SW_W-1:0]          fsm_sw,
  output logic                     fsm_ctrl,
  output logic                     fsm_reset,
  input  logic [ST_W-1:0]          fsm_state,
  input  logic                     fsm_out,
  output logic [DEPTH-1:0]         trace,
  output logic [ST_W-1:0]          last_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   len_clamped;
  logic [SW_W-1:0] sw_q;
  logic [SW_W-1:0] script_rd;
  logic            script_we;
  logic            last_step;
  logic            run_start;

  assign len_clamped = LW'(clamp_len(32'(len), $unsigned(DEPTH)));
  assign last_step   = ({1'b0, idx} + LW'(1)) == len_q;
  assign run_start   = (state == IDLE) && start;
  assign script_we   = (state == IDLE) && wr_en;

  moore_seq_script #(
    .DEPTH (DEPTH),
    .SW_W  (SW_W)
  ) u_script (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (script_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (script_rd)
  );

  // Next-state and output decode. Outputs are pure functions of the state
  // (Moore style) except fsm_sw, which shows the fresh script symbol during
  // DRIVE and the held copy everywhere else. clr_fsm is consumed here at the
  // start edge: its only effect is the choice of CLR versus DRIVE, so the
  // state register itself carries the latched decision.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fsm_ctrl  = 1'b0;
    fsm_reset = 1'b0;
    fsm_sw    = sw_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            state_nxt = DONE;
          end else if (clr_fsm) begin
            state_nxt = CLR;
          end else begin
            state_nxt = DRIVE;
          end
        end
      end
      CLR: begin
        busy      = 1'b1;
        fsm_reset = 1'b1;
        state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        fsm_sw    = script_rd;
        state_nxt = STEP;
      end
      STEP: begin
        busy     = 1'b1;
        fsm_ctrl = 1'b1;
`ifdef MOORE_SEQ_TRACE_EN
        state_nxt = CAPT;
`else
        state_nxt = last_step ? DONE : DRIVE;
`endif
      end
`ifdef MOORE_SEQ_TRACE_EN
      CAPT: begin
        busy      = 1'b1;
        state_nxt = last_step ? DONE : DRIVE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus the run bookkeeping: the clamped length and step
  // index are loaded at start, the switch symbol is latched in DRIVE so it
  // stays stable through STEP and after the run, and the index advances on
  // the last cycle of each step that is not the final one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      len_q <= '0;
      sw_q  <= '0;
    end else begin
      state <= state_nxt;
      if (run_start) begin
        len_q <= len_clamped;
        idx   <= '0;
      end
      if (state == DRIVE) begin
        sw_q <= script_rd;
      end
`ifdef MOORE_SEQ_TRACE_EN
      if ((state == CAPT) && !last_step) begin
        idx <= idx + IW'(1);
      end
`else
      if ((state == STEP) && !last_step) begin
        idx <= idx + IW'(1);
      end
`endif
    end
  end

`ifdef MOORE_SEQ_TRACE_EN
  logic [DEPTH-1:0] trace_q;
  logic [ST_W-1:0]  last_state_q;

  // Capture of the core's response. The core moves on the edge that ends
  // STEP, so during CAPT fsm_out/fsm_state already show the post-step values.
  // These registers deliberately survive reset: the previous run's result
  // stays readable until the next start clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (run_start) begin
        trace_q      <= '0;
        last_state_q <= '0;
      end else if (state == CAPT) begin
        trace_q[idx] <= fsm_out;
        last_state_q <= fsm_state;
      end
    end
  end

  assign trace      = trace_q;
  assign last_state = last_state_q;
`else
  logic unused_core_obs;

  assign unused_core_obs = ^{fsm_out, fsm_state};
  assign trace           = '0;
  assign last_state      = '0;
`endif

endmodule
